// File: rtl/spi_exchange_arbiter_if.sv
// Requester and engine side signals of the SPI exchange arbiter.
// The master modport is the requesters plus the exchange engine; the slave modport is the arbiter.
interface spi_exchange_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8
);
    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ-1:0]            lock;
    logic [NUM_REQ*DATA_WIDTH-1:0] send_data;
    logic [NUM_REQ-1:0]            ack;
    logic                          err;
    logic [DATA_WIDTH-1:0]         recv_data;
    logic [NUM_REQ-1:0]            grant;
    logic                          spi_exchange;
    logic                          spi_select;
    logic [DATA_WIDTH-1:0]         spi_send_data;
    logic                          spi_busy;
    logic                          spi_ready;
    logic [DATA_WIDTH-1:0]         spi_recv_data;

    modport master (
        output req, lock, send_data, spi_busy, spi_ready, spi_recv_data,
        input  ack, err, recv_data, grant, spi_exchange, spi_select, spi_send_data
    );

    modport slave (
        input  req, lock, send_data, spi_busy, spi_ready, spi_recv_data,
        output ack, err, recv_data, grant, spi_exchange, spi_select, spi_send_data
    );
endinterface

// File: rtl/spi_exchange_arbiter.sv
// Round-robin arbiter sharing one SPI byte-exchange engine between NUM_REQ requesters,
// with locked (CS-held) multi-byte bursts and a watchdog on the engine's completion.
module spi_exchange_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int REQ_IDX    = 2,
    parameter int DATA_WIDTH = 8,
    parameter int TIMEOUT_W  = 16
) (
    input  logic                  clk_i,
    input  logic                  arst_n_i,
    input  logic                  soft_rst_i,
    spi_exchange_arbiter_if.slave bus
);
    typedef enum logic [2:0] {IDLE, LAUNCH, WAIT, DONE, HOLD} state_t;

    localparam logic [TIMEOUT_W-1:0] WD_MAX  = '1;
    localparam logic [TIMEOUT_W-1:0] WD_LAST = WD_MAX - 1'b1;

    state_t                state;
    logic [REQ_IDX-1:0]    ptr;
    logic [REQ_IDX-1:0]    owner;
    logic [TIMEOUT_W-1:0]  wd;
    logic [NUM_REQ-1:0]    grant_r;
    logic [NUM_REQ-1:0]    ack_r;
    logic                  err_r;
    logic                  exch_r;
    logic                  sel_r;
    logic [DATA_WIDTH-1:0] send_r;
    logic [DATA_WIDTH-1:0] recv_r;

    logic [REQ_IDX-1:0]    cand;
    logic [REQ_IDX-1:0]    pick_idx;
    logic                  pick_vld;
    logic [DATA_WIDTH-1:0] pick_byte;
    logic [DATA_WIDTH-1:0] owner_byte;

    function automatic logic [REQ_IDX-1:0] wrap_inc(input logic [REQ_IDX-1:0] idx);
        return (idx == REQ_IDX'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
    endfunction

    function automatic logic [NUM_REQ-1:0] onehot(input logic [REQ_IDX-1:0] idx);
        return NUM_REQ'(1) << idx;
    endfunction

    // Search starts at the pointer and wraps, so the last-served requester goes to the back.
    always_comb begin
        cand     = ptr;
        pick_idx = ptr;
        pick_vld = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!pick_vld && bus.req[cand]) begin
                pick_vld = 1'b1;
                pick_idx = cand;
            end
            cand = wrap_inc(cand);
        end
    end

    assign pick_byte  = bus.send_data[int'(pick_idx) * DATA_WIDTH +: DATA_WIDTH];
    assign owner_byte = bus.send_data[int'(owner) * DATA_WIDTH +: DATA_WIDTH];

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state   <= IDLE;
            ptr     <= '0;
            owner   <= '0;
            wd      <= '0;
            grant_r <= '0;
            ack_r   <= '0;
            err_r   <= 1'b0;
            exch_r  <= 1'b0;
            sel_r   <= 1'b0;
            send_r  <= '0;
            recv_r  <= '0;
        end else if (soft_rst_i) begin
            state   <= IDLE;
            ptr     <= '0;
            owner   <= '0;
            wd      <= '0;
            grant_r <= '0;
            ack_r   <= '0;
            err_r   <= 1'b0;
            exch_r  <= 1'b0;
            sel_r   <= 1'b0;
            send_r  <= '0;
            recv_r  <= '0;
        end else begin
            ack_r <= '0;
            err_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        owner   <= pick_idx;
                        grant_r <= onehot(pick_idx);
                        sel_r   <= 1'b1;
                        send_r  <= pick_byte;
                        exch_r  <= 1'b1;
                        wd      <= '0;
                        state   <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    if (bus.spi_busy) begin
                        exch_r <= 1'b0;
                        state  <= WAIT;
                    end
                end
                WAIT: begin
                    if (bus.spi_ready) begin
                        recv_r <= bus.spi_recv_data;
                        ack_r  <= onehot(owner);
                        state  <= DONE;
                    end else if (wd == WD_LAST) begin
                        // Stalled engine: complete the transfer with an error, keep the old byte.
                        wd     <= WD_MAX;
                        ack_r  <= onehot(owner);
                        err_r  <= 1'b1;
                        state  <= DONE;
                    end else begin
                        wd <= wd + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.lock[owner]) begin
                        state <= HOLD;
                    end else begin
                        grant_r <= '0;
                        sel_r   <= 1'b0;
                        ptr     <= wrap_inc(owner);
                        state   <= IDLE;
                    end
                end
                HOLD: begin
                    // A pending byte wins over a simultaneous unlock; release follows that byte.
                    if (bus.req[owner]) begin
                        send_r <= owner_byte;
                        exch_r <= 1'b1;
                        wd     <= '0;
                        state  <= LAUNCH;
                    end else if (!bus.lock[owner]) begin
                        grant_r <= '0;
                        sel_r   <= 1'b0;
                        ptr     <= wrap_inc(owner);
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.grant         = grant_r;
    assign bus.ack           = ack_r;
    assign bus.err           = err_r;
    assign bus.recv_data     = recv_r;
    assign bus.spi_exchange  = exch_r;
    assign bus.spi_select    = sel_r;
    assign bus.spi_send_data = send_r;
endmodule

// File: tb/tb_spi_exchange_arbiter.sv
// Bench for spi_exchange_arbiter: vector table, corner-case sequences and a randomized
// run against a transaction-level round-robin model, with a simple engine model attached.
module tb_spi_exchange_arbiter;
    localparam int N  = 4;
    localparam int DW = 8;

    logic clk_i = 1'b0;
    logic arst_n_i;
    logic soft_rst_i;

    spi_exchange_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(DW)) bus ();

    spi_exchange_arbiter #(
        .NUM_REQ   (N),
        .REQ_IDX   (2),
        .DATA_WIDTH(DW),
        .TIMEOUT_W (4)
    ) dut (
        .clk_i     (clk_i),
        .arst_n_i  (arst_n_i),
        .soft_rst_i(soft_rst_i),
        .bus       (bus)
    );

    always #5 clk_i = ~clk_i;

    // Engine model: picks up the strobe, goes busy after eng_bd cycles, ready after eng_bd+eng_rd.
    int        busy_dly = 2;
    int        ready_dly = 8;
    bit        eng_rand = 1'b0;
    bit        eng_hang = 1'b0;
    logic [7:0] tb_byte = 8'h00;
    bit        eng_active;
    int        eng_cnt;
    int        eng_bd;
    int        eng_rd;
    logic [7:0] eng_cur;

    always @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i || soft_rst_i) begin
            eng_active        <= 1'b0;
            eng_cnt           <= 0;
            bus.spi_busy      <= 1'b0;
            bus.spi_ready     <= 1'b0;
            bus.spi_recv_data <= '0;
        end else begin
            bus.spi_ready <= 1'b0;
            if (!eng_active) begin
                if (bus.spi_exchange) begin
                    eng_active <= 1'b1;
                    eng_cnt    <= 0;
                    if (eng_rand) begin
                        eng_bd  <= $urandom_range(1, 3);
                        eng_rd  <= $urandom_range(1, 6);
                        eng_cur <= 8'($urandom);
                    end else begin
                        eng_bd  <= busy_dly;
                        eng_rd  <= ready_dly;
                        eng_cur <= tb_byte;
                    end
                end
            end else begin
                eng_cnt <= eng_cnt + 1;
                if (eng_cnt + 1 >= eng_bd) bus.spi_busy <= 1'b1;
                if (!eng_hang && eng_cnt + 1 >= eng_bd + eng_rd) begin
                    bus.spi_busy      <= 1'b0;
                    bus.spi_ready     <= 1'b1;
                    bus.spi_recv_data <= eng_cur;
                    eng_active        <= 1'b0;
                end
            end
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic flag_fail(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: bounded wait expired", name);
    endtask

    task automatic wait_ack(input int limit, output int cycles, output bit ok);
        ok     = 1'b0;
        cycles = 0;
        while (cycles < limit) begin
            @(negedge clk_i);
            cycles++;
            if (bus.ack != '0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_exchange_fall(input string name);
        int c;
        c = 0;
        while (bus.spi_exchange && c < 50) begin
            @(negedge clk_i);
            c++;
        end
        if (bus.spi_exchange) flag_fail(name);
    endtask

    typedef struct {
        logic [3:0]  req;
        logic [31:0] data;
        logic [7:0]  eng;
        logic [3:0]  exp_grant;
        logic [7:0]  exp_send;
    } vec_t;

    vec_t tbl [10];

    initial begin
        #400000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        int         cyc;
        bit         ok;
        int         nbytes;
        bit         sel_ok;
        bit         stolen;
        bit         bad_send;
        logic [7:0] cur_byte;
        logic [7:0] last_recv;
        bit         flag;
        int         ptr_m;
        int         m_owner;
        int         exp_i;
        int         acked;
        int         n_acks;
        bit         m_busy;
        bit         raise_en;
        logic [3:0] applied;

        tbl[0] = '{4'b1111, 32'h44332211, 8'h10, 4'b0001, 8'h11};
        tbl[1] = '{4'b1111, 32'h44332211, 8'h20, 4'b0010, 8'h22};
        tbl[2] = '{4'b1111, 32'h44332211, 8'h30, 4'b0100, 8'h33};
        tbl[3] = '{4'b1111, 32'h44332211, 8'h40, 4'b1000, 8'h44};
        tbl[4] = '{4'b1111, 32'h88776655, 8'h50, 4'b0001, 8'h55};
        tbl[5] = '{4'b0010, 32'h0000A500, 8'h3C, 4'b0010, 8'hA5};
        tbl[6] = '{4'b0011, 32'h0000BBAA, 8'h61, 4'b0001, 8'hAA};
        tbl[7] = '{4'b1001, 32'hDD0000CC, 8'h72, 4'b1000, 8'hDD};
        tbl[8] = '{4'b0100, 32'h00EE0000, 8'h83, 4'b0100, 8'hEE};
        tbl[9] = '{4'b1000, 32'hFF000000, 8'h94, 4'b1000, 8'hFF};

        arst_n_i      = 1'b0;
        soft_rst_i    = 1'b0;
        bus.req       = '0;
        bus.lock      = '0;
        bus.send_data = '0;
        repeat (3) @(negedge clk_i);
        chk("rst_grant", 32'(bus.grant), 32'h0);
        chk("rst_ack", 32'(bus.ack), 32'h0);
        chk("rst_err", 32'(bus.err), 32'h0);
        chk("rst_recv", 32'(bus.recv_data), 32'h0);
        chk("rst_strobe", 32'(bus.spi_exchange), 32'h0);
        chk("rst_select", 32'(bus.spi_select), 32'h0);
        chk("rst_send", 32'(bus.spi_send_data), 32'h0);
        arst_n_i = 1'b1;
        @(negedge clk_i);

        // Vector table: fairness rotation, single transfer, wrap-around arbitration.
        for (int k = 0; k < 10; k++) begin
            bus.send_data = tbl[k].data;
            tb_byte       = tbl[k].eng;
            bus.req       = tbl[k].req;
            @(negedge clk_i);
            chk("vec_strobe", 32'(bus.spi_exchange), 32'h1);
            chk("vec_grant", 32'(bus.grant), 32'(tbl[k].exp_grant));
            chk("vec_select", 32'(bus.spi_select), 32'h1);
            chk("vec_send", 32'(bus.spi_send_data), 32'(tbl[k].exp_send));
            wait_ack(40, cyc, ok);
            if (!ok) flag_fail("vec_ack_wait");
            chk("vec_ack", 32'(bus.ack), 32'(tbl[k].exp_grant));
            chk("vec_recv", 32'(bus.recv_data), 32'(tbl[k].eng));
            chk("vec_err", 32'(bus.err), 32'h0);
            bus.req = '0;
            @(negedge clk_i);
            chk("vec_ack_pulse", 32'(bus.ack), 32'h0);
            chk("vec_release", 32'(bus.grant), 32'h0);
            chk("vec_recv_held", 32'(bus.recv_data), 32'(tbl[k].eng));
        end

        // Lock burst: three bytes to requester 2 while requester 0 waits.
        cur_byte      = 8'hC1;
        bus.send_data = {8'h00, cur_byte, 8'h00, 8'h0A};
        tb_byte       = 8'h71;
        bus.lock      = 4'b0100;
        bus.req       = 4'b0100;
        @(negedge clk_i);
        chk("lock_grant", 32'(bus.grant), 32'h4);
        bus.req[0] = 1'b1;
        nbytes   = 0;
        sel_ok   = 1'b1;
        stolen   = 1'b0;
        bad_send = 1'b0;
        cyc      = 0;
        while (nbytes < 3 && cyc < 200) begin
            @(negedge clk_i);
            cyc++;
            if (!bus.spi_select) sel_ok = 1'b0;
            if (bus.grant != 4'b0100) stolen = 1'b1;
            if (bus.spi_exchange && bus.spi_send_data != cur_byte) bad_send = 1'b1;
            if (bus.ack != '0) begin
                chk("lock_ack", 32'(bus.ack), 32'h4);
                chk("lock_recv", 32'(bus.recv_data), 32'(tb_byte));
                nbytes++;
                bus.req[2] = 1'b0;
                if (nbytes == 3) begin
                    bus.lock[2] = 1'b0;
                end else begin
                    @(negedge clk_i);
                    cyc++;
                    if (!bus.spi_select) sel_ok = 1'b0;
                    if (bus.grant != 4'b0100) stolen = 1'b1;
                    cur_byte                = cur_byte + 8'h01;
                    bus.send_data[23:16]    = cur_byte;
                    tb_byte                 = tb_byte + 8'h11;
                    bus.req[2]              = 1'b1;
                end
            end
        end
        chk("lock_bytes", 32'(nbytes), 32'd3);
        chk("lock_select_held", 32'(sel_ok), 32'h1);
        chk("lock_no_steal", 32'(stolen), 32'h0);
        chk("lock_send_bytes", 32'(bad_send), 32'h0);
        tb_byte = 8'h5E;
        @(negedge clk_i);
        chk("lock_release", 32'(bus.grant), 32'h0);
        @(negedge clk_i);
        chk("lock_then_req0", 32'(bus.grant), 32'h1);
        wait_ack(40, cyc, ok);
        chk("lock_req0_ack", 32'(bus.ack), 32'h1);
        last_recv = tb_byte;
        bus.req = '0;
        @(negedge clk_i);

        // Watchdog: engine goes busy and never finishes.
        eng_hang = 1'b1;
        bus.req  = 4'b0010;
        @(negedge clk_i);
        chk("wd_grant", 32'(bus.grant), 32'h2);
        wait_exchange_fall("wd_launch_wait");
        wait_ack(40, cyc, ok);
        chk("wd_cycles", 32'(cyc), 32'd15);
        chk("wd_ack", 32'(bus.ack), 32'h2);
        chk("wd_err", 32'(bus.err), 32'h1);
        chk("wd_recv_held", 32'(bus.recv_data), 32'(last_recv));
        bus.req = '0;
        @(negedge clk_i);
        chk("wd_err_pulse", 32'(bus.err), 32'h0);
        chk("wd_idle", 32'(bus.grant), 32'h0);
        eng_hang = 1'b0;
        repeat (3) @(negedge clk_i);

        // Requester 2 drops in WAIT (still served), requester 0 drops before grant (never served).
        tb_byte = 8'h66;
        bus.req = 4'b0101;
        @(negedge clk_i);
        chk("drop_grant", 32'(bus.grant), 32'h4);
        wait_exchange_fall("drop_launch_wait");
        bus.req = '0;
        wait_ack(40, cyc, ok);
        chk("drop_wait_ack", 32'(bus.ack), 32'h4);
        chk("drop_wait_recv", 32'(bus.recv_data), 32'h66);
        flag = 1'b0;
        repeat (10) begin
            @(negedge clk_i);
            if (bus.spi_exchange || bus.grant != '0) flag = 1'b1;
        end
        chk("drop_no_strobe", 32'(flag), 32'h0);

        // Soft reset while in WAIT.
        bus.req = 4'b0100;
        @(negedge clk_i);
        chk("srst_grant", 32'(bus.grant), 32'h4);
        wait_exchange_fall("srst_launch_wait");
        @(negedge clk_i);
        soft_rst_i = 1'b1;
        bus.req    = '0;
        @(negedge clk_i);
        soft_rst_i = 1'b0;
        chk("srst_grant0", 32'(bus.grant), 32'h0);
        chk("srst_select0", 32'(bus.spi_select), 32'h0);
        chk("srst_strobe0", 32'(bus.spi_exchange), 32'h0);
        chk("srst_recv0", 32'(bus.recv_data), 32'h0);
        chk("srst_send0", 32'(bus.spi_send_data), 32'h0);
        flag = 1'b0;
        repeat (12) begin
            @(negedge clk_i);
            if (bus.ack != '0 || bus.err) flag = 1'b1;
        end
        chk("srst_no_ack", 32'(flag), 32'h0);

        // Async reset mid-LAUNCH, with the pointer moved off zero first.
        tb_byte = 8'h99;
        bus.req = 4'b0001;
        wait_ack(40, cyc, ok);
        chk("arst_pre_ack", 32'(bus.ack), 32'h1);
        bus.req = '0;
        @(negedge clk_i);
        bus.req = 4'b1000;
        @(negedge clk_i);
        chk("arst_launch", 32'(bus.spi_exchange), 32'h1);
        chk("arst_launch_grant", 32'(bus.grant), 32'h8);
        bus.req = '0;
        #2 arst_n_i = 1'b0;
        #1;
        chk("arst_grant0", 32'(bus.grant), 32'h0);
        chk("arst_strobe0", 32'(bus.spi_exchange), 32'h0);
        chk("arst_select0", 32'(bus.spi_select), 32'h0);
        @(negedge clk_i);
        arst_n_i = 1'b1;
        bus.req  = 4'b0011;
        @(negedge clk_i);
        chk("arst_ptr0", 32'(bus.grant), 32'h1);
        wait_ack(40, cyc, ok);
        chk("arst_post_ack", 32'(bus.ack), 32'h1);
        bus.req = '0;
        @(negedge clk_i);

        // Randomized traffic against a transaction-level round-robin model.
        eng_rand = 1'b1;
        ptr_m    = 1;
        m_busy   = 1'b0;
        m_owner  = 0;
        n_acks   = 0;
        for (int c = 0; c < 2400; c++) begin
            raise_en = (c < 2000);
            if (!raise_en && bus.req == '0 && !m_busy && bus.grant == '0) break;
            @(negedge clk_i);
            applied = bus.req;
            acked   = -1;
            if (bus.grant != '0 && !m_busy) begin
                exp_i = -1;
                for (int j = 0; j < N; j++)
                    if (exp_i < 0 && applied[(ptr_m + j) % N]) exp_i = (ptr_m + j) % N;
                if (exp_i < 0) begin
                    chk("rand_spurious_grant", 32'(bus.grant), 32'h0);
                end else begin
                    chk("rand_grant", 32'(bus.grant), 32'(1) << exp_i);
                    chk("rand_send", 32'(bus.spi_send_data), 32'(bus.send_data[exp_i*DW +: DW]));
                    m_owner = exp_i;
                    m_busy  = 1'b1;
                end
            end
            if (bus.ack != '0) begin
                if (!m_busy) begin
                    chk("rand_spurious_ack", 32'(bus.ack), 32'h0);
                end else begin
                    chk("rand_ack", 32'(bus.ack), 32'(1) << m_owner);
                    chk("rand_recv", 32'(bus.recv_data), 32'(eng_cur));
                    chk("rand_err", 32'(bus.err), 32'h0);
                    bus.req[m_owner] = 1'b0;
                    acked  = m_owner;
                    ptr_m  = (m_owner + 1) % N;
                    m_busy = 1'b0;
                    n_acks++;
                end
            end
            if (raise_en) begin
                for (int i = 0; i < N; i++) begin
                    if (!bus.req[i] && i != acked && $urandom_range(0, 3) == 0) begin
                        bus.send_data[i*DW +: DW] = 8'($urandom);
                        bus.req[i] = 1'b1;
                    end
                end
            end
        end
        chk("rand_drained", 32'(bus.req == '0 && !m_busy), 32'h1);
        chk("rand_enough_acks", 32'(n_acks >= 50), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
